bsg_fmul_iter: RTL and testbench

BSG_FMUL_ITER -- requirements
Module: bsg_fmul_iter

---
 rtl/bsg_fmul_iter.sv | 228 ++++++++++++++++++++++
 tb/tb_bsg_fmul_iter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fmul_iter.sv
// Iterative IEEE-754 multiplier: radix-2 shift-add significand product,
// round-to-nearest-even, flush-to-zero on subnormal inputs and results.
module bsg_fmul_iter #(
    parameter int exp_p = 8,
    parameter int sig_p = 23
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 v_i,
    input  logic [exp_p+sig_p:0] a_i,
    input  logic [exp_p+sig_p:0] b_i,
    output logic                 ready_o,
    output logic                 v_o,
    output logic [exp_p+sig_p:0] z_o,
    output logic [3:0]           fflags_o,
    input  logic                 yumi_i
);

    localparam int w  = exp_p + sig_p + 1;
    localparam int m  = sig_p + 1;
    localparam int pw = 2 * m;
    localparam int ew = exp_p + 2;
    localparam int cw = $clog2(m);

    localparam logic [ew-1:0] bias_c = ew'((2 ** (exp_p - 1)) - 1);
    localparam logic [ew-1:0] emax_c = ew'((2 ** exp_p) - 1);
    localparam logic [cw-1:0] last_c = cw'(m - 1);
    localparam logic [w-1:0]  qnan_c =
        {1'b0, {exp_p{1'b1}}, 1'b1, {(sig_p-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_e;

    state_e state_r, state_n;

    logic          sgn_r;
    logic [ew-1:0] exp_r;
    logic [pw-1:0] mcand_r;
    logic [m-1:0]  mplier_r;
    logic [pw-1:0] prod_r;
    logic [cw-1:0] cnt_r;

    // operand field split and class decode
    logic             sa, sb;
    logic [exp_p-1:0] ea, eb;
    logic [sig_p-1:0] fa, fb;
    logic             a_zero, b_zero;
    logic             a_inf, b_inf;
    logic             a_nan, b_nan;
    logic             a_snan, b_snan;
    logic             sgn;
    logic             inv_op;
    logic             any_nan;
    logic             special;

    assign sa = a_i[w-1];
    assign sb = b_i[w-1];
    assign ea = a_i[w-2:sig_p];
    assign eb = b_i[w-2:sig_p];
    assign fa = a_i[sig_p-1:0];
    assign fb = b_i[sig_p-1:0];

    // exp==0 covers subnormals too: they are flushed to signed zero
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_snan = a_nan & ~fa[sig_p-1];
    assign b_snan = b_nan & ~fb[sig_p-1];

    assign sgn     = sa ^ sb;
    assign inv_op  = (a_inf & b_zero) | (b_inf & a_zero);
    assign any_nan = a_nan | b_nan;
    assign special = a_zero | b_zero | a_inf | b_inf | any_nan;

    // result for operands that bypass the multiply loop
    logic [w-1:0] spec_z;
    logic [3:0]   spec_f;

    always_comb begin
        spec_z = {sgn, {(w-1){1'b0}}};
        spec_f = 4'b0000;
        if (any_nan | inv_op) begin
            spec_z = qnan_c;
            spec_f = {a_snan | b_snan | inv_op, 3'b000};
        end else if (a_inf | b_inf) begin
            spec_z = {sgn, {exp_p{1'b1}}, {sig_p{1'b0}}};
        end
    end

    logic [ew-1:0] exp_sum;

    assign exp_sum = ew'(ea) + ew'(eb) - bias_c;

    // normalise, round and range-check the finished product
    logic             hi;
    logic [m-1:0]     mant;
    logic             guard;
    logic             sticky;
    logic             rnd_up;
    logic [m:0]       mant_rnd;
    logic             carry;
    logic [sig_p-1:0] frac_n;
    logic [ew-1:0]    exp_n;
    logic             ovf;
    logic             unf;
    logic [w-1:0]     norm_z;
    logic [3:0]       norm_f;

    assign hi     = prod_r[pw-1];
    assign mant   = hi ? prod_r[pw-1 -: m] : prod_r[pw-2 -: m];
    assign guard  = hi ? prod_r[sig_p] : prod_r[sig_p-1];
    assign sticky = (|prod_r[sig_p-2:0]) | (hi & prod_r[sig_p-1]);
    assign rnd_up = guard & (sticky | mant[0]);

    assign mant_rnd = {1'b0, mant} + {{m{1'b0}}, rnd_up};
    assign carry    = mant_rnd[m];
    assign frac_n   = carry ? mant_rnd[sig_p:1] : mant_rnd[sig_p-1:0];
    assign exp_n    = exp_r + ew'(hi) + ew'(carry);

    assign ovf = $signed(exp_n) >= $signed(emax_c);
    assign unf = $signed(exp_n) <= $signed({ew{1'b0}});

    always_comb begin
        norm_z = {sgn_r, exp_n[exp_p-1:0], frac_n};
        norm_f = {3'b000, guard | sticky};
        if (ovf) begin
            norm_z = {sgn_r, {exp_p{1'b1}}, {sig_p{1'b0}}};
            norm_f = 4'b0101;
        end else if (unf) begin
            norm_z = {sgn_r, {(w-1){1'b0}}};
            norm_f = 4'b0011;
        end
    end

    // state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // next-state: specials skip straight to DONE, normals iterate
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            IDLE: begin
                if (v_i) begin
                    state_n = special ? DONE : MUL;
                end
            end
            MUL: begin
                if (cnt_r == last_c) begin
                    state_n = NORM;
                end
            end
            NORM: begin
                state_n = DONE;
            end
            DONE: begin
                if (yumi_i) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // operand capture, shift-add iteration and result registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sgn_r    <= 1'b0;
            exp_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            prod_r   <= '0;
            cnt_r    <= '0;
            z_o      <= '0;
            fflags_o <= '0;
        end else begin
            unique case (state_r)
                IDLE: begin
                    if (v_i) begin
                        sgn_r <= sgn;
                        if (special) begin
                            z_o      <= spec_z;
                            fflags_o <= spec_f;
                        end else begin
                            exp_r    <= exp_sum;
                            mcand_r  <= {{m{1'b0}}, 1'b1, fa};
                            mplier_r <= {1'b1, fb};
                            prod_r   <= '0;
                            cnt_r    <= '0;
                        end
                    end
                end
                MUL: begin
                    if (mplier_r[0]) begin
                        prod_r <= prod_r + mcand_r;
                    end
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + cw'(1);
                end
                NORM: begin
                    z_o      <= norm_z;
                    fflags_o <= norm_f;
                end
                default: begin
                end
            endcase
        end
    end

    assign ready_o = (state_r == IDLE);
    assign v_o     = (state_r == DONE);

endmodule

// File: tb/tb_bsg_fmul_iter.sv
// Randomised and directed bench for bsg_fmul_iter against an
// integer-arithmetic model of single-precision multiplication.
module tb_bsg_fmul_iter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        ready_o;
    logic        v_o;
    logic [31:0] z_o;
    logic [3:0]  fflags_o;
    logic        yumi_i;

    int n_tests = 0;
    int n_fail  = 0;

    bsg_fmul_iter dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .v_i      (v_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .ready_o  (ready_o),
        .v_o      (v_o),
        .z_o      (z_o),
        .fflags_o (fflags_o),
        .yumi_i   (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // product rules in plain integer arithmetic
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] z,
                                    output logic [3:0] f, output int lat);
        logic s;
        int ea, eb, e, sh;
        logic [22:0] fa, fb;
        bit za, zb, ia, ib, na, nb, sn, inv;
        longint unsigned p, q, r, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (fa == 0);
        ib = (eb == 255) && (fb == 0);
        na = (ea == 255) && (fa != 0);
        nb = (eb == 255) && (fb != 0);
        sn = (na && !fa[22]) || (nb && !fb[22]);
        inv = (ia && zb) || (ib && za);
        lat = 1;
        f = 4'b0000;
        if (na || nb || inv) begin
            z = 32'h7FC0_0000;
            f[3] = sn || inv;
        end else if (ia || ib) begin
            z = {s, 8'hFF, 23'h0};
        end else if (za || zb) begin
            z = {s, 31'h0};
        end else begin
            lat = 26;
            p = 64'({1'b1, fa}) * 64'({1'b1, fb});
            e = ea + eb - 127;
            sh = 23;
            if (p >= (64'd1 << 47)) begin
                sh = 24;
                e++;
            end
            q = p >> sh;
            r = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (r > half || (r == half && q[0])) q++;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e++;
            end
            if (e >= 255) begin
                z = {s, 8'hFF, 23'h0};
                f = 4'b0101;
            end else if (e <= 0) begin
                z = {s, 31'h0};
                f = 4'b0011;
            end else begin
                z = {s, 8'(e), q[22:0]};
                f = {3'b000, r != 0};
            end
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        int k;
        logic [22:0] f;
        logic [7:0] e;
        k = $urandom_range(0, 15);
        f = 23'($urandom);
        if (k == 0) begin
            e = 8'h00;
        end else if (k == 1) begin
            e = 8'hFF;
            case ($urandom_range(0, 2))
                0: f = 23'h0;
                1: f[22] = 1'b1;
                default: begin
                    f[22] = 1'b0;
                    f[0] = 1'b1;
                end
            endcase
        end else if (k < 5) begin
            e = 8'($urandom_range(1, 254));
        end else begin
            e = 8'($urandom_range(100, 154));
        end
        return {1'($urandom), e, f};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ez, input logic [3:0] ef,
                          input int el, input int hold);
        int lat;
        @(negedge clk_i);
        check("ready_idle", ready_o, 1);
        a_i = a;
        b_i = b;
        v_i = 1'b1;
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
        lat = 1;
        while (!v_o && lat < 100) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        check("latency", lat, el);
        check("z", z_o, ez);
        check("fflags", fflags_o, ef);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            check("hold_v", v_o, 1);
            check("hold_ready", ready_o, 0);
            check("hold_z", z_o, ez);
            check("hold_f", fflags_o, ef);
            v_i = 1'($urandom);
            a_i = $urandom;
            b_i = $urandom;
        end
        @(negedge clk_i);
        v_i = 1'b0;
        yumi_i = 1'b1;
        @(posedge clk_i);
        #1;
        yumi_i = 1'b0;
        check("post_yumi_v", v_o, 0);
        check("post_yumi_ready", ready_o, 1);
    endtask

    task automatic run_rand();
        logic [31:0] a, b, ez;
        logic [3:0] ef;
        int el;
        a = rnd_op();
        b = rnd_op();
        ref_mul(a, b, ez, ef, el);
        run_op(a, b, ez, ef, el, $urandom_range(0, 3));
    endtask

    initial begin
        bit seen_v;
        bit seen_z;
        reset_i = 1'b1;
        v_i = 1'b0;
        yumi_i = 1'b0;
        a_i = '0;
        b_i = '0;
        #1;
        check("rst_ready", ready_o, 1);
        check("rst_v", v_o, 0);
        check("rst_z", z_o, 0);
        check("rst_f", fflags_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'h0, 26, 0);
        run_op(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'h1, 26, 0);
        run_op(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'h0, 26, 0);
        run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'h8, 1, 0);
        run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'h0, 1, 0);
        run_op(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 4'h5, 26, 10);
        run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'h3, 26, 0);
        run_op(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 4'h1, 26, 0);
        run_op(32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, 4'h1, 26, 0);
        run_op(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 4'h1, 26, 0);
        run_op(32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'h8, 1, 0);
        run_op(32'h7FC0_0000, 32'h0000_0000, 32'h7FC0_0000, 4'h0, 1, 0);
        run_op(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'h0, 1, 0);
        run_op(32'h0040_0000, 32'hC000_0000, 32'h8000_0000, 4'h0, 1, 0);

        @(negedge clk_i);
        a_i = 32'h3F80_0000;
        b_i = 32'h3F80_0000;
        v_i = 1'b1;
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        #1;
        check("midrst_ready", ready_o, 1);
        check("midrst_v", v_o, 0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        seen_v = 1'b0;
        seen_z = 1'b0;
        repeat (30) begin
            @(negedge clk_i);
            seen_v |= v_o;
            seen_z |= (z_o != 0) || (fflags_o != 0);
        end
        check("abort_no_v", seen_v, 0);
        check("abort_zero_out", seen_z, 0);
        run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'h0, 26, 0);

        for (int i = 0; i < 60; i++) begin
            run_rand();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
